// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FIX,
      DONE
   } div_state_e;

   localparam logic [3:0] FN_DIV  = 4'd4;
   localparam logic [3:0] FN_DIVU = 4'd5;
   localparam logic [3:0] FN_REM  = 4'd6;
   localparam logic [3:0] FN_REMU = 4'd7;

   localparam int WORD_W = 32;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate with optional
// sign-extension of the low word.
module div_sign_fix
   import div_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] val,
   input  logic            neg,
   input  logic            word,
   output logic [XLEN-1:0] res
);

   logic [XLEN-1:0] n;

   assign n = neg ? -val : val;

   assign res = word
      ? {{(XLEN-WORD_W){n[WORD_W-1]}}, n[WORD_W-1:0]}
      : n;

endmodule

// File: rtl/iter_div_core.sv
// Radix-2 restoring divider, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN skips iterations for b==0 or |a|<|b|.
module iter_div_core
   import div_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_req_valid,
   output logic            io_req_ready,
   input  logic [3:0]      io_req_bits_fn,
   input  logic            io_req_bits_dw,
   input  logic [XLEN-1:0] io_req_bits_in1,
   input  logic [XLEN-1:0] io_req_bits_in2,
   input  logic            io_kill,
   input  logic            io_resp_ready,
   output logic            io_resp_valid,
   output logic [XLEN-1:0] io_resp_bits_data
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0] N_FULL = CW'(XLEN);
   localparam logic [CW-1:0] N_WORD = CW'(WORD_W);
   localparam logic [CW-1:0] ONE    = CW'(1);

   div_state_e state;
   logic [CW-1:0] cnt;
   logic [XLEN-1:0] q;
   logic [XLEN-1:0] r;
   logic [XLEN-1:0] b_mag;
   logic neg_q;
   logic neg_r;
   logic rem_sel;
   logic word;

   logic is_uns;
   logic [XLEN-1:0] a_n;
   logic [XLEN-1:0] b_n;
   logic a_sign;
   logic b_sign;
   logic b_zero;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag_in;
   logic unused_fn;

   assign is_uns = io_req_bits_fn[0];
   assign unused_fn = ^io_req_bits_fn[3:2];

   always_comb begin
      a_n = io_req_bits_in1;
      b_n = io_req_bits_in2;
      if (!io_req_bits_dw) begin
         a_n = {{(XLEN-WORD_W){!is_uns & io_req_bits_in1[WORD_W-1]}},
                io_req_bits_in1[WORD_W-1:0]};
         b_n = {{(XLEN-WORD_W){!is_uns & io_req_bits_in2[WORD_W-1]}},
                io_req_bits_in2[WORD_W-1:0]};
      end
   end

   assign a_sign = !is_uns & a_n[XLEN-1];
   assign b_sign = !is_uns & b_n[XLEN-1];
   assign b_zero = (b_n == '0);

   div_sign_fix #(.XLEN(XLEN)) u_mag_a (
      .val  (a_n),
      .neg  (a_sign),
      .word (1'b0),
      .res  (a_mag)
   );

   div_sign_fix #(.XLEN(XLEN)) u_mag_b (
      .val  (b_n),
      .neg  (b_sign),
      .word (1'b0),
      .res  (b_mag_in)
   );

   // One restoring step: shift in next dividend bit, subtract if it fits.
   logic [XLEN:0] r_sh;
   logic [XLEN:0] diff;
   logic ge;
   logic [XLEN-1:0] r_nx;

   assign r_sh = {r, q[XLEN-1]};
   assign diff = r_sh - {1'b0, b_mag};
   assign ge   = !diff[XLEN];
   assign r_nx = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];

   logic [XLEN-1:0] res_raw;
   logic res_neg;
   logic [XLEN-1:0] res_fix;

   assign res_raw = rem_sel ? r : q;
   assign res_neg = rem_sel ? neg_r : neg_q;

   div_sign_fix #(.XLEN(XLEN)) u_fix_res (
      .val  (res_raw),
      .neg  (res_neg),
      .word (word),
      .res  (res_fix)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         cnt               <= '0;
         q                 <= '0;
         r                 <= '0;
         b_mag             <= '0;
         neg_q             <= 1'b0;
         neg_r             <= 1'b0;
         rem_sel           <= 1'b0;
         word              <= 1'b0;
         io_req_ready      <= 1'b1;
         io_resp_valid     <= 1'b0;
         io_resp_bits_data <= '0;
      end else if (io_kill && state != IDLE) begin
         state         <= IDLE;
         io_req_ready  <= 1'b1;
         io_resp_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (io_req_valid && !io_kill) begin
                  b_mag        <= b_mag_in;
                  neg_q        <= (a_sign ^ b_sign) & !b_zero;
                  neg_r        <= a_sign;
                  rem_sel      <= io_req_bits_fn[1];
                  word         <= !io_req_bits_dw;
                  io_req_ready <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
                  if (b_zero || a_mag < b_mag_in) begin
                     q     <= b_zero ? '1 : '0;
                     r     <= a_mag;
                     cnt   <= '0;
                     state <= FIX;
                  end else
`endif
                  begin
                     r     <= '0;
                     q     <= io_req_bits_dw ? a_mag : (a_mag << WORD_W);
                     cnt   <= io_req_bits_dw ? N_FULL : N_WORD;
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               r   <= r_nx;
               q   <= {q[XLEN-2:0], ge};
               cnt <= cnt - ONE;
               if (cnt == ONE) state <= FIX;
            end
            FIX: begin
               io_resp_bits_data <= res_fix;
               io_resp_valid     <= 1'b1;
               state             <= DONE;
            end
            DONE: begin
               if (io_resp_ready) begin
                  io_resp_valid <= 1'b0;
                  io_req_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
